// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter feeding one serial byte transmitter: grants a byte, pulses
// tx_load/ack, holds tx_active for one frame, then enforces an idle gap.
module tx_frame_arbiter #(
  parameter int N            = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CLKS     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [8*N-1:0]       req_data,
  output logic [N-1:0]         ack,
  output logic                 tx_load,
  output logic [7:0]           tx_data,
  output logic                 tx_active,
  output logic [3:0]           tx_bit,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [15:0]          frames_sent
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(GAP_CLKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] clk_cnt;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] win;
  logic          hit;
  int            j;

  // First requester found walking up from ptr, wrapping at N.
  always_comb begin
    win = '0;
    hit = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!hit && req[j]) begin
        hit = 1'b1;
        win = IW'(j);
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state == S_LOAD) ack[grant_id] = 1'b1;
  end

  assign tx_load   = (state == S_LOAD);
  assign tx_active = (state == S_SEND);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      clk_cnt     <= '0;
      gap_cnt     <= '0;
      tx_data     <= '0;
      tx_bit      <= '0;
      grant_id    <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        S_IDLE: if (hit) begin
          tx_data  <= req_data[8*win +: 8];
          grant_id <= win;
          ptr      <= IW'((int'(win) + 1) % N);
          tx_bit   <= '0;
          clk_cnt  <= '0;
          state    <= S_LOAD;
        end
        S_LOAD: state <= S_SEND;
        S_SEND: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            // tx_bit stays on the stop bit through the gap.
            if (tx_bit == 4'(FRAME_BITS - 1)) begin
              state       <= S_GAP;
              gap_cnt     <= '0;
              frames_sent <= frames_sent + 16'd1;
            end else begin
              tx_bit <= tx_bit + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          if (gap_cnt == GW'(GAP_CLKS - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter at default parameters (N=4, 16 clk/bit,
// 10-bit frames, 16-clock gap); expected values are hand-derived timings.
module tb_tx_frame_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  ack;
  logic          tx_load;
  logic [7:0]    tx_data;
  logic          tx_active;
  logic [3:0]    tx_bit;
  logic          busy;
  logic [1:0]    grant_id;
  logic [15:0]   frames_sent;

  int vec = 0;
  int miss = 0;

  tx_frame_arbiter #(.N(N), .CLKS_PER_BIT(16), .FRAME_BITS(10), .GAP_CLKS(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_load(tx_load), .tx_data(tx_data), .tx_active(tx_active), .tx_bit(tx_bit),
    .busy(busy), .grant_id(grant_id), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  // Ticks until tx_load is seen; n = ticks taken, ok = 0 on timeout.
  task automatic wait_load(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 400) begin
      tick();
      n++;
      if (tx_load) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    tick();
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (tx_active !== 1'b0) begin miss++; $display("FAIL reset_tx_active got %b want 0", tx_active); end
    vec++; if (ack !== 4'b0000 || tx_load !== 1'b0) begin miss++; $display("FAIL reset_ack_load got %b/%b want 0000/0", ack, tx_load); end
    vec++; if (tx_data !== 8'h00 || tx_bit !== 4'd0) begin miss++; $display("FAIL reset_data_bit got %h/%0d want 00/0", tx_data, tx_bit); end
    vec++; if (grant_id !== 2'd0 || frames_sent !== 16'd0) begin miss++; $display("FAIL reset_gid_frames got %0d/%0d want 0/0", grant_id, frames_sent); end
    reset = 1'b0;
    req   = '0;
  endtask

  task automatic test_single();
    int active, lowat;
    apply_reset();
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    tick();
    vec++; if (ack !== 4'b0001 || tx_load !== 1'b1) begin miss++; $display("FAIL single_ack got %b/%b want 0001/1", ack, tx_load); end
    vec++; if (tx_data !== 8'hA5) begin miss++; $display("FAIL single_data got %h want a5", tx_data); end
    req = '0;
    active = 0;
    lowat  = 0;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (tx_active) active++;
      if (!busy && lowat == 0) lowat = t + 1;
      if (t == 17) begin
        vec++; if (tx_bit !== 4'd1) begin miss++; $display("FAIL single_txbit1 got %0d want 1", tx_bit); end
      end
      if (t == 160) begin
        vec++; if (tx_active !== 1'b1 || frames_sent !== 16'd0) begin miss++; $display("FAIL single_last_send got %b/%0d want 1/0", tx_active, frames_sent); end
      end
      if (t == 161) begin
        vec++; if (tx_active !== 1'b0 || frames_sent !== 16'd1 || tx_bit !== 4'd9) begin
          miss++; $display("FAIL single_first_gap got act=%b frames=%0d bit=%0d want 0/1/9", tx_active, frames_sent, tx_bit); end
      end
    end
    vec++; if (active != 160) begin miss++; $display("FAIL single_active_len got %0d want 160", active); end
    vec++; if (lowat != 178) begin miss++; $display("FAIL single_busy_len got %0d want 178", lowat); end
    vec++; if (frames_sent !== 16'd1) begin miss++; $display("FAIL single_frames got %0d want 1", frames_sent); end
  endtask

  task automatic test_all_four();
    int n;
    bit ok;
    logic [7:0] exp;
    apply_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int e = 0; e < 4; e++) begin
      wait_load(n, ok);
      exp = 8'((e + 1) * 17);
      vec++; if (!ok) begin miss++; $display("FAIL all4_timeout grant %0d got none want load", e); end
      vec++; if (grant_id !== 2'(e) || ack !== (4'b0001 << e)) begin miss++; $display("FAIL all4_grant got %0d/%b want %0d", grant_id, ack, e); end
      vec++; if (tx_data !== exp) begin miss++; $display("FAIL all4_data got %h want %h", tx_data, exp); end
      if (e > 0) begin
        vec++; if (n != 178) begin miss++; $display("FAIL all4_spacing got %0d want 178", n); end
      end
      req[e] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int n;
    bit ok;
    int exp;
    apply_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0001;
    for (int e = 0; e < 4; e++) begin
      wait_load(n, ok);
      exp = (e % 2) * 2;
      vec++; if (!ok || grant_id !== 2'(exp) || ack !== (4'b0001 << exp)) begin
        miss++; $display("FAIL fair_grant%0d got %0d/%b want %0d", e, grant_id, ack, exp); end
      vec++; if ((ack & ~req) !== 4'b0000) begin miss++; $display("FAIL fair_idle_ack got %b req %b", ack, req); end
      if (e == 0) req[2] = 1'b1;
    end
  endtask

  task automatic test_withdrawn();
    int n, loads;
    bit ok, seen1;
    apply_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0001;
    wait_load(n, ok);
    req = '0;
    for (int t = 0; t < 20; t++) tick();
    vec++; if (tx_active !== 1'b1) begin miss++; $display("FAIL wd_in_send got %b want 1", tx_active); end
    seen1 = 1'b0;
    loads = 0;
    req[1] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (ack[1]) seen1 = 1'b1;
    end
    req = '0;
    for (int t = 0; t < 250; t++) begin
      tick();
      if (ack[1]) seen1 = 1'b1;
      if (tx_load) loads++;
    end
    vec++; if (seen1 || loads != 0) begin miss++; $display("FAIL wd_acked got ack1=%b loads=%0d want 0/0", seen1, loads); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL wd_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    apply_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0001;
    wait_load(n, ok);
    req = '0;
    for (int t = 0; t < 80; t++) tick();
    vec++; if (tx_active !== 1'b1) begin miss++; $display("FAIL rmid_pre got %b want 1", tx_active); end
    reset = 1'b1;
    tick();
    vec++; if (tx_active !== 1'b0 || busy !== 1'b0) begin miss++; $display("FAIL rmid_drop got act=%b busy=%b want 0/0", tx_active, busy); end
    vec++; if (frames_sent !== 16'd0) begin miss++; $display("FAIL rmid_frames got %0d want 0", frames_sent); end
    reset = 1'b0;
    req = 4'b0011;
    wait_load(n, ok);
    vec++; if (!ok || grant_id !== 2'd0 || ack !== 4'b0001 || tx_data !== 8'h11) begin
      miss++; $display("FAIL rmid_ptr got gid=%0d ack=%b data=%h want 0/0001/11", grant_id, ack, tx_data); end
    req = '0;
  endtask

  task automatic test_wrap();
    int n, active;
    bit ok;
    apply_reset();
    force dut.frames_sent = 16'hFFFF;
    tick();
    release dut.frames_sent;
    tick();
    vec++; if (frames_sent !== 16'hFFFF) begin miss++; $display("FAIL wrap_preset got %h want ffff", frames_sent); end
    req_data[7:0] = 8'h5A;
    req = 4'b0001;
    wait_load(n, ok);
    req = '0;
    active = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (tx_active) active++;
    end
    vec++; if (frames_sent !== 16'h0000) begin miss++; $display("FAIL wrap_frames got %h want 0000", frames_sent); end
    vec++; if (!ok || active != 160 || busy !== 1'b0) begin miss++; $display("FAIL wrap_frame got ok=%b act=%0d busy=%b want 1/160/0", ok, active, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_withdrawn();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Round-robin scheduler that shares the serial byte transmitter between N byte-producing requesters. It accepts one byte at a time through a req/ack handshake and hands it to the transmitter with a one-cycle load pulse. It then frames the transmission by holding the transmitter's transmit-enable for exactly one 10-bit frame and enforcing an idle gap before the next grant. It sits between the application-side byte sources and the send path's load/transmit-enable inputs.

## Interface
- N, 4, number of requesters (2..8)
- CLKS_PER_BIT, 16, clocks per serial bit; must match the transmitter's bit-period counter
- FRAME_BITS, 10, bits per frame (start + 8 data + stop)
- GAP_CLKS, 16, idle clocks between frames (>=1)

- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- req  input  N  per-requester byte request; held until acked
- req_data  input  8*N  byte for requester i on req_data[8i+7:8i]
- ack  output  N  one-cycle pulse, one-hot, byte from requester i accepted
- tx_load  output  1  one-cycle load pulse to transmitter
- tx_data  output  8  byte to transmitter; registered, stable from LOAD through end of SEND
- tx_active  output  1  transmit enable to transmitter; high for whole frame
- tx_bit  output  4  index of bit currently on the line during SEND (0..FRAME_BITS-1)
- busy  output  1  high whenever state != IDLE
- grant_id  output  $clog2(N)  index of most recently granted requester
- frames_sent  output  16  completed-frame counter, wraps at 2^16

## Operation
- States: IDLE, LOAD, SEND, GAP.
- IDLE: if any req bit is set, select a winner by round-robin, register tx_data <= winner's byte and grant_id <= winner, then go to LOAD. Otherwise stay.
- Round-robin: search starts at pointer ptr and proceeds ptr, ptr+1, … mod N. After granting i, ptr <= (i+1) mod N.
- LOAD (1 cycle): tx_load=1, ack[grant_id]=1, then go to SEND.
- SEND: tx_active=1. Clock counter clk_cnt runs 0..CLKS_PER_BIT-1. tx_bit increments when clk_cnt wraps.
  - On the cycle with tx_bit=FRAME_BITS-1 and clk_cnt=CLKS_PER_BIT-1, go to GAP and increment frames_sent.
- GAP: tx_active=0. Stay for GAP_CLKS cycles, then go to IDLE.
- Requesters not granted keep req high. They are not acked and are reconsidered in the next IDLE.
- Requester protocol:
  - The acked requester may drop req or present a new byte in the cycle after ack.
  - Data is sampled only at the IDLE→LOAD edge. Changes to req_data at any other time are ignored.
  - If req is deasserted before it is sampled in IDLE, it is never acked.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits and the gap counter is $clog2(GAP_CLKS+1) bits. frames_sent wraps 0xFFFF→0x0000 with no flag.

## Timing
- Reset values: state=IDLE, ptr=0, ack=0, tx_load=0, tx_data=0, tx_active=0, tx_bit=0, busy=0, grant_id=0, frames_sent=0.
- Reset mid-operation returns to the reset state on the next edge. tx_active drops the cycle after reset is sampled, and the frame in progress is abandoned without an ack.
- req sampled high in IDLE at edge k gives:
  - ack/tx_load high in cycle k+1;
  - tx_active high cycles k+2 .. k+1+FRAME_BITS*CLKS_PER_BIT (160 cycles at defaults);
  - GAP for 16 cycles, then IDLE.
- Back-to-back throughput with req held continuously: one byte per 1+1+160+16 = 178 clocks, as IDLE→LOAD→SEND(160)→GAP(16).
- tx_bit changes on the edge after clk_cnt=CLKS_PER_BIT-1. It holds its value through GAP and resets to 0 on entering LOAD.
- frames_sent updates on the SEND→GAP edge and is visible in the first GAP cycle.
- Exactly one of ack is ever high, and only in LOAD. tx_load and the ack pulse are coincident.

## Test plan
- Single request: req=0001, req_data[7:0]=0xA5 → ack=0001 and tx_load in the cycle after sampling, tx_data=0xA5, tx_active high for exactly 160 cycles, frames_sent=1, busy low after 178 cycles.
- All four requesting from reset with bytes 0x11,0x22,0x33,0x44, each held until acked → grants in order 0,1,2,3, with tx_data matching each, at 178-cycle spacing.
- Fairness: req0 held permanently, req2 asserted after the first grant → grant sequence 0,2,0,2. grant_id matches and ack is never given to an idle requester.
- Withdrawn request: req1 pulsed for 5 cycles during another requester's SEND → req1 never acked, and the next IDLE with no other requests stays IDLE.
- Reset mid-SEND (cycle 80 of the frame) → tx_active=0 and busy=0 one cycle later, frames_sent=0, and the next grant goes to requester 0 even if ptr was nonzero.
- Counter wrap: force frames_sent=0xFFFF, complete one frame → frames_sent=0x0000, with no other behavioural change.
